fft_frame_scheduler: RTL and testbench

- Sequences FFT magnitude frames into the visualizer's spectrum RAM write port (`i_fft_addr` / `i_fft_mag` / `i_fft_valid` of `fft_vga_visualizer`).
- Sits in the `sys_clk` domain between the FFT core's streaming output and the visualizer.
- Validates frame framing, decimates the display refresh rate and supports a freeze control.
- Applies optional per-bin peak-hold with exponential decay, using an internal hold RAM that is cleared by a post-reset sweep.

---
 rtl/fft_frame_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - FFT frame sequencer with decimation, freeze and per-bin peak-hold
module fft_frame_scheduler #(
   parameter int N_BINS      = 512,
   parameter int ADDR_W      = 9,
   parameter int MAG_W       = 24,
   parameter int DECAY_SHIFT = 4,
   parameter int FRAME_DIV   = 1
) (
   input  logic              sys_clk,
   input  logic              sys_reset,
   input  logic              i_valid,
   input  logic              i_sop,
   input  logic              i_eop,
   input  logic [MAG_W-1:0]  i_mag,
   input  logic              i_freeze,
   input  logic              i_peak_en,
   output logic [ADDR_W-1:0] o_fft_addr,
   output logic [MAG_W-1:0]  o_fft_mag,
   output logic              o_fft_valid,
   output logic              o_frame_done,
   output logic              o_frame_err,
   output logic [15:0]       o_frame_cnt
);

   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(FRAME_DIV - 1);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RUN, S_SKIP} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] bin_cnt, bin_n, s_addr;
   logic [DIV_W-1:0]  div_cnt, div_n, div_inc;
   logic              start_run, wr_en, done_en, err_en;

   // pipeline stage 1 (input register + hold RAM read)
   logic              s1_valid, s1_last, s1_peak;
   logic [ADDR_W-1:0] s1_addr;
   logic [MAG_W-1:0]  s1_mag, hold_q;

   // stage 2 compute
   logic [MAG_W-1:0]  decayed, result;

   logic [MAG_W-1:0]  hold_ram [N_BINS];
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [MAG_W-1:0]  ram_wdata;

   assign start_run = (div_cnt == '0) && !i_freeze;
   assign div_inc   = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

   // next-state, bin/decimation counters and per-sample pipeline controls
   always_comb begin
      state_n = state;
      bin_n   = bin_cnt;
      div_n   = div_cnt;
      s_addr  = bin_cnt;
      wr_en   = 1'b0;
      done_en = 1'b0;
      err_en  = 1'b0;
      case (state)
         S_CLEAR: begin
            if (bin_cnt == LAST_BIN) begin
               state_n = S_IDLE;
               bin_n   = '0;
            end else begin
               bin_n = bin_cnt + 1'b1;
            end
         end
         S_IDLE: begin
            if (i_valid && i_sop) begin
               state_n = start_run ? S_RUN : S_SKIP;
               bin_n   = ADDR_W'(1);
               s_addr  = '0;
               wr_en   = start_run;
               div_n   = div_inc;
            end
         end
         default: begin
            if (i_valid) begin
               if (i_sop) begin
                  // a stray sop aborts the frame and restarts as bin 0 of a new one
                  err_en  = (bin_cnt != '0);
                  state_n = start_run ? S_RUN : S_SKIP;
                  bin_n   = ADDR_W'(1);
                  s_addr  = '0;
                  wr_en   = start_run;
                  div_n   = div_inc;
               end else begin
                  wr_en = (state == S_RUN);
                  if (bin_cnt == LAST_BIN) begin
                     state_n = S_IDLE;
                     bin_n   = '0;
                     if (i_eop) begin
                        done_en = (state == S_RUN);
                     end else begin
                        err_en = 1'b1;
                     end
                  end else if (i_eop) begin
                     err_en  = 1'b1;
                     state_n = S_IDLE;
                     bin_n   = '0;
                  end else begin
                     bin_n = bin_cnt + 1'b1;
                  end
               end
            end
         end
      endcase
   end

   // state and counter registers
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state   <= S_CLEAR;
         bin_cnt <= '0;
         div_cnt <= '0;
      end else begin
         state   <= state_n;
         bin_cnt <= bin_n;
         div_cnt <= div_n;
      end
   end

   // stage 1 register; in-flight samples are dropped on reset
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_peak  <= 1'b0;
         s1_addr  <= '0;
         s1_mag   <= '0;
      end else begin
         s1_valid <= wr_en;
         s1_last  <= done_en;
         s1_peak  <= i_peak_en;
         s1_addr  <= s_addr;
         s1_mag   <= i_mag;
      end
   end

   assign decayed = hold_q - (hold_q >> DECAY_SHIFT);
   assign result  = (s1_peak && (decayed > s1_mag)) ? decayed : s1_mag;

   assign ram_we    = !sys_reset && ((state == S_CLEAR) || s1_valid);
   assign ram_waddr = (state == S_CLEAR) ? bin_cnt : s1_addr;
   assign ram_wdata = (state == S_CLEAR) ? '0 : result;

   // hold RAM: synchronous read at the sample bin, write-back of the stage 2 result
   always_ff @(posedge sys_clk) begin
      if (ram_we) begin
         hold_ram[ram_waddr] <= ram_wdata;
      end
      hold_q <= hold_ram[s_addr];
   end

   // stage 2 output register toward the visualizer write port
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         o_fft_valid  <= 1'b0;
         o_fft_addr   <= '0;
         o_fft_mag    <= '0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         o_frame_cnt  <= '0;
      end else begin
         o_frame_err <= err_en;
         if (state == S_CLEAR) begin
            o_fft_valid  <= 1'b1;
            o_fft_addr   <= bin_cnt;
            o_fft_mag    <= '0;
            o_frame_done <= 1'b0;
         end else begin
            o_fft_valid  <= s1_valid;
            o_fft_addr   <= s1_addr;
            o_fft_mag    <= result;
            o_frame_done <= s1_valid && s1_last;
            if (s1_valid && s1_last) begin
               o_frame_cnt <= o_frame_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - directed table-driven bench for fft_frame_scheduler
module tb_fft_frame_scheduler;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int MW = 24;

   logic          clk = 1'b0;
   logic          sys_reset;
   logic          valid, sop, eop, freeze, peak_en;
   logic [MW-1:0] mag;

   logic [AW-1:0] fft_addr, a2;
   logic [MW-1:0] fft_mag, m2;
   logic          fft_valid, frame_done, frame_err, v2, d2, e2;
   logic [15:0]   frame_cnt, c2;

   fft_frame_scheduler #(.N_BINS(N), .ADDR_W(AW), .MAG_W(MW), .DECAY_SHIFT(1), .FRAME_DIV(1)) dut (
      .sys_clk(clk), .sys_reset(sys_reset), .i_valid(valid), .i_sop(sop), .i_eop(eop),
      .i_mag(mag), .i_freeze(freeze), .i_peak_en(peak_en),
      .o_fft_addr(fft_addr), .o_fft_mag(fft_mag), .o_fft_valid(fft_valid),
      .o_frame_done(frame_done), .o_frame_err(frame_err), .o_frame_cnt(frame_cnt));

   fft_frame_scheduler #(.N_BINS(N), .ADDR_W(AW), .MAG_W(MW), .DECAY_SHIFT(1), .FRAME_DIV(2)) dut2 (
      .sys_clk(clk), .sys_reset(sys_reset), .i_valid(valid), .i_sop(sop), .i_eop(eop),
      .i_mag(mag), .i_freeze(freeze), .i_peak_en(peak_en),
      .o_fft_addr(a2), .o_fft_mag(m2), .o_fft_valid(v2),
      .o_frame_done(d2), .o_frame_err(e2), .o_frame_cnt(c2));

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int mag;
      int done;
      int cyc;
   } wr_t;

   typedef struct {
      int base;
      int step;
      bit peak;
      bit gap;
      int ebase;
      int estep;
   } fr_t;

   wr_t log_q[$];
   int  cyc = 0;
   int  err_n = 0;
   int  err_cyc = 0;
   int  w2_n = 0;
   int  checks = 0;
   int  errors = 0;
   int  d_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fft_valid) log_q.push_back('{int'(fft_addr), int'(fft_mag), int'(frame_done), cyc});
      if (frame_err) begin
         err_n   = err_n + 1;
         err_cyc = cyc;
      end
      if (v2) w2_n = w2_n + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic put(input logic v, input logic s, input logic e, input int m, input logic p, input logic f);
      valid   = v;
      sop     = s;
      eop     = e;
      mag     = MW'(m);
      peak_en = p;
      freeze  = f;
      d_cyc   = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic chk_sweep(input string name);
      chk({name, "_nwr"}, log_q.size(), N);
      for (int k = 0; k < N && k < log_q.size(); k++) begin
         chk({name, "_addr"}, log_q[k].addr, k);
         chk({name, "_mag"}, log_q[k].mag, 0);
         chk({name, "_cyc"}, log_q[k].cyc - log_q[0].cyc, k);
      end
   endtask

   function automatic int done_count();
      int n = 0;
      foreach (log_q[i]) n += log_q[i].done;
      return n;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fr_t tbl[7];
      int  dc[N];
      int  e0;
      int  rcyc;
      int  exp_addr[11];
      int  w2_exp[4];

      tbl[0] = '{0,   10, 1'b0, 1'b0, 0,   10};
      tbl[1] = '{100, 0,  1'b0, 1'b1, 100, 0};
      tbl[2] = '{0,   0,  1'b1, 1'b0, 50,  0};
      tbl[3] = '{0,   0,  1'b1, 1'b1, 25,  0};
      tbl[4] = '{20,  1,  1'b1, 1'b0, 20,  1};
      tbl[5] = '{0,   0,  1'b0, 1'b0, 0,   0};
      tbl[6] = '{9,   0,  1'b1, 1'b0, 9,   0};

      sys_reset = 1'b1;
      valid = 0; sop = 0; eop = 0; mag = '0; freeze = 0; peak_en = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", int'(fft_valid), 0);
      chk("rst_cnt", int'(frame_cnt), 0);
      chk("rst_err", int'(frame_err), 0);
      chk("rst_done", int'(frame_done), 0);

      // reset release: sop during the sweep must be ignored
      log_q.delete();
      w2_n = 0;
      err_n = 0;
      sys_reset = 1'b0;
      for (int i = 0; i < 3; i++) put(1'b1, 1'b1, 1'b0, 77, 1'b0, 1'b0);
      idle(12);
      chk_sweep("clear");
      chk("clear_err", err_n, 0);
      chk("clear_w2", w2_n, N);

      // back-to-back frames with hand-computed expected magnitudes
      for (int i = 0; i < 7; i++) begin
         log_q.delete();
         e0 = err_n;
         for (int k = 0; k < N; k++) begin
            if (tbl[i].gap && k == 3) idle(1);
            dc[k] = cyc;
            put(1'b1, k == 0, k == N - 1, tbl[i].base + tbl[i].step * k, tbl[i].peak, 1'b0);
         end
         idle(4);
         chk("frm_nwr", log_q.size(), N);
         for (int k = 0; k < N && k < log_q.size(); k++) begin
            chk("frm_addr", log_q[k].addr, k);
            chk("frm_mag", log_q[k].mag, tbl[i].ebase + tbl[i].estep * k);
            chk("frm_done", log_q[k].done, (k == N - 1) ? 1 : 0);
            chk("frm_lat", log_q[k].cyc - dc[k], 2);
         end
         chk("frm_err", err_n - e0, 0);
         chk("frm_cnt", int'(frame_cnt), i + 1);
      end

      // eop at bin 5
      log_q.delete();
      e0 = err_n;
      for (int k = 0; k < 6; k++) put(1'b1, k == 0, k == 5, 7, 1'b0, 1'b0);
      rcyc = d_cyc;
      idle(4);
      chk("eop5_nwr", log_q.size(), 6);
      chk("eop5_err", err_n - e0, 1);
      chk("eop5_errcyc", err_cyc - rcyc, 1);
      chk("eop5_done", done_count(), 0);
      chk("eop5_cnt", int'(frame_cnt), 7);

      // sop at bin 3 restarts the frame
      log_q.delete();
      e0 = err_n;
      exp_addr = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7};
      for (int k = 0; k < 3; k++) put(1'b1, k == 0, 1'b0, 5, 1'b0, 1'b0);
      rcyc = cyc;
      for (int k = 0; k < N; k++) put(1'b1, k == 0, k == N - 1, 5, 1'b0, 1'b0);
      idle(4);
      chk("sop3_nwr", log_q.size(), 11);
      for (int k = 0; k < 11 && k < log_q.size(); k++) chk("sop3_addr", log_q[k].addr, exp_addr[k]);
      chk("sop3_err", err_n - e0, 1);
      chk("sop3_errcyc", err_cyc - rcyc, 1);
      chk("sop3_done", done_count(), 1);
      if (log_q.size() == 11) chk("sop3_lastdone", log_q[10].done, 1);
      chk("sop3_cnt", int'(frame_cnt), 8);

      // bin 7 without eop
      log_q.delete();
      e0 = err_n;
      for (int k = 0; k < N; k++) put(1'b1, k == 0, 1'b0, 3, 1'b0, 1'b0);
      rcyc = d_cyc;
      idle(4);
      chk("noeop_nwr", log_q.size(), N);
      chk("noeop_err", err_n - e0, 1);
      chk("noeop_errcyc", err_cyc - rcyc, 1);
      chk("noeop_done", done_count(), 0);
      chk("noeop_cnt", int'(frame_cnt), 8);

      // freeze at sop suppresses the frame; freeze elsewhere is not sampled
      log_q.delete();
      e0 = err_n;
      for (int k = 0; k < N; k++) put(1'b1, k == 0, k == N - 1, 4, 1'b0, k == 0);
      idle(4);
      chk("frz_nwr", log_q.size(), 0);
      chk("frz_err", err_n - e0, 0);
      chk("frz_cnt", int'(frame_cnt), 8);
      log_q.delete();
      for (int k = 0; k < N; k++) put(1'b1, k == 0, k == N - 1, 4, 1'b0, k != 0);
      idle(4);
      chk("unfrz_nwr", log_q.size(), N);
      chk("unfrz_cnt", int'(frame_cnt), 9);

      // reset in the middle of a frame
      for (int k = 0; k < 4; k++) put(1'b1, k == 0, 1'b0, 11, 1'b0, 1'b0);
      sys_reset = 1'b1;
      put(1'b1, 1'b0, 1'b0, 11, 1'b0, 1'b0);
      sys_reset = 1'b0;
      valid = 1'b0;
      log_q.delete();
      w2_n = 0;
      e0 = err_n;
      chk("mrst_valid", int'(fft_valid), 0);
      chk("mrst_addr", int'(fft_addr), 0);
      chk("mrst_mag", int'(fft_mag), 0);
      chk("mrst_cnt", int'(frame_cnt), 0);
      chk("mrst_cnt2", int'(c2), 0);
      idle(14);
      chk_sweep("mrst");
      chk("mrst_err", err_n - e0, 0);
      chk("mrst_w2", w2_n, N);

      // decimation by 2 on the second instance
      w2_exp = '{N, 0, N, 0};
      for (int f = 0; f < 4; f++) begin
         w2_n = 0;
         for (int k = 0; k < N; k++) put(1'b1, k == 0, k == N - 1, 10 * k, 1'b0, 1'b0);
         idle(3);
         chk("div_w2", w2_n, w2_exp[f]);
      end
      chk("div_cnt2", int'(c2), 2);
      chk("div_cnt1", int'(frame_cnt), 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
